// File: rtl/dphy_hs_lane_aligner.sv
// dphy_hs_lane_aligner: multi-lane D-PHY HS receive back-end (sync hunt, bit alignment, lane deskew)
//   byte_clk_i      byte clock, all logic on rising edge
//   rst_n_i         asynchronous active-low reset
//   active_lanes_i  active lane count (0 or >LANES means LANES), sampled on HS entry
//   hs_active_i     high during an HS burst; low returns to idle and flushes
//   byte_data_i     raw deserialised bytes, lane n at [8n+7:8n], bit 0 earliest
//   aligned_data_o  deskewed, bit-aligned payload, same packing, inactive lanes 0
//   aligned_valid_o aligned_data_o holds one byte per active lane
//   lane_locked_o   per-lane sync lock status
//   sync_err_o      one-cycle pulse on sync timeout
//   skew_err_o      one-cycle pulse on deskew FIFO overflow
module dphy_hs_lane_aligner #(
    parameter int         LANES        = 4,
    parameter logic [7:0] SYNC_BYTE    = 8'hB8,
    parameter int         SYNC_TIMEOUT = 64,
    parameter int         DESKEW_DEPTH = 4
) (
    input  logic               byte_clk_i,
    input  logic               rst_n_i,
    input  logic [2:0]         active_lanes_i,
    input  logic               hs_active_i,
    input  logic [LANES*8-1:0] byte_data_i,
    output logic [LANES*8-1:0] aligned_data_o,
    output logic               aligned_valid_o,
    output logic [LANES-1:0]   lane_locked_o,
    output logic               sync_err_o,
    output logic               skew_err_o
);
    localparam int AW = $clog2(DESKEW_DEPTH);
    localparam int CW = $clog2(SYNC_TIMEOUT + 1);
    localparam logic [2:0] MAXL = 3'(LANES);
    localparam logic [AW:0] FULL = (AW+1)'(DESKEW_DEPTH);

    typedef enum logic [1:0] {IDLE, HUNT, LOCKED, ERR} state_t;

    state_t             st_q   [LANES];
    state_t             st_d   [LANES];
    logic [7:0]         prev_q [LANES];
    logic [2:0]         off_q  [LANES];
    logic [2:0]         off_d  [LANES];
    logic [7:0]         mem_q  [LANES][DESKEW_DEPTH];
    logic [AW-1:0]      wr_q   [LANES];
    logic [AW-1:0]      wr_d   [LANES];
    logic [AW-1:0]      rd_q   [LANES];
    logic [AW-1:0]      rd_d   [LANES];
    logic [AW:0]        fcnt_q [LANES];
    logic [AW:0]        fcnt_d [LANES];
    logic [LANES-1:0]   act_q, act_d, lock_q, lock_d;
    logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [LANES*8-1:0] data_q, data_d;
    logic               valid_q, valid_d, sync_err_q, sync_err_d, skew_err_q, skew_err_d;

    logic [15:0]        win       [LANES];
    logic [7:0]         lane_byte [LANES];
    logic [2:0]         hit_k     [LANES];
    logic [LANES-1:0]   act_new, hit, push, wen, popn, empty, full;
    logic [2:0]         n_eff;
    logic               run, all_locked, pop, hunting, timeout, overflow, flush;

    always_comb begin
        n_eff = (active_lanes_i == 3'd0 || active_lanes_i > MAXL) ? MAXL : active_lanes_i;
        run   = st_q[0] == HUNT || st_q[0] == LOCKED;
        data_d = '0;
        for (int n = 0; n < LANES; n++) begin
            act_new[n] = 3'(n) < n_eff;
            win[n] = {byte_data_i[8*n +: 8], prev_q[n]};
            hit[n] = 1'b0;
            hit_k[n] = 3'd0;
            // descending scan so the lowest matching offset wins
            for (int k = 7; k >= 0; k--) begin
                if (win[n][k +: 8] == SYNC_BYTE) begin
                    hit[n] = 1'b1;
                    hit_k[n] = 3'(k);
                end
            end
            lane_byte[n] = win[n][off_q[n] +: 8];
            push[n]  = st_q[n] == LOCKED;
            empty[n] = fcnt_q[n] == '0;
            full[n]  = fcnt_q[n] == FULL;
        end
        all_locked = (act_q & ~lock_q) == '0;
        pop        = run && ((empty & act_q) == '0);
        // while a lane is still hunting, early lanes just stall at full; once every
        // lane is locked a push into a full FIFO means the skew exceeds the FIFO
        overflow   = run && hs_active_i && all_locked && !pop && |(push & full);
        hunting    = run && |(act_q & ~lock_q & ~hit);
        cnt_inc    = cnt_q + 1'b1;
        timeout    = hunting && hs_active_i && cnt_inc == CW'(SYNC_TIMEOUT);
        flush      = !hs_active_i || !run || timeout || overflow;
        cnt_d      = !run ? '0 : hunting ? cnt_inc : cnt_q;
        act_d      = (st_q[0] == IDLE && hs_active_i) ? act_new : act_q;
        valid_d    = pop && !flush;
        sync_err_d = timeout;
        skew_err_d = overflow;
        for (int n = 0; n < LANES; n++) begin
            st_d[n] = !hs_active_i ? IDLE :
                      (timeout || overflow) ? ERR :
                      st_q[n] == IDLE ? HUNT :
                      (st_q[n] == HUNT && act_q[n] && hit[n]) ? LOCKED : st_q[n];
            lock_d[n] = hs_active_i && (lock_q[n] || st_d[n] == LOCKED);
            off_d[n]  = (st_q[n] == HUNT && hit[n]) ? hit_k[n] : off_q[n];
            wen[n]    = push[n] && (!full[n] || pop) && !flush;
            popn[n]   = pop && act_q[n] && !flush;
            wr_d[n]   = flush ? '0 : wr_q[n] + AW'(wen[n]);
            rd_d[n]   = flush ? '0 : rd_q[n] + AW'(popn[n]);
            fcnt_d[n] = flush ? '0 : fcnt_q[n] + (AW+1)'(wen[n]) - (AW+1)'(popn[n]);
            data_d[8*n +: 8] = popn[n] ? mem_q[n][rd_q[n]] : 8'h00;
        end
    end

    always_ff @(posedge byte_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int n = 0; n < LANES; n++) begin
                st_q[n]   <= IDLE;
                prev_q[n] <= '0;
                off_q[n]  <= '0;
                wr_q[n]   <= '0;
                rd_q[n]   <= '0;
                fcnt_q[n] <= '0;
            end
            act_q      <= '0;
            lock_q     <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
            skew_err_q <= 1'b0;
        end else begin
            for (int n = 0; n < LANES; n++) begin
                st_q[n]   <= st_d[n];
                prev_q[n] <= byte_data_i[8*n +: 8];
                off_q[n]  <= off_d[n];
                wr_q[n]   <= wr_d[n];
                rd_q[n]   <= rd_d[n];
                fcnt_q[n] <= fcnt_d[n];
            end
            act_q      <= act_d;
            lock_q     <= lock_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sync_err_q <= sync_err_d;
            skew_err_q <= skew_err_d;
        end
    end

    always_ff @(posedge byte_clk_i) begin
        for (int n = 0; n < LANES; n++) begin
            if (wen[n]) mem_q[n][wr_q[n]] <= lane_byte[n];
        end
    end

    assign aligned_data_o  = data_q;
    assign aligned_valid_o = valid_q;
    assign lane_locked_o   = lock_q;
    assign sync_err_o      = sync_err_q;
    assign skew_err_o      = skew_err_q;
endmodule

// File: tb/tb_dphy_hs_lane_aligner.sv
// tb_dphy_hs_lane_aligner: vector table plus scoreboard bench for dphy_hs_lane_aligner
module tb_dphy_hs_lane_aligner;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  al;
    logic        hs;
    logic [31:0] din;
    logic [31:0] dout;
    logic        valid;
    logic [3:0]  locked;
    logic        sync_err, skew_err;

    int          tests = 0;
    int          fails = 0;
    logic        sb_on = 1'b0;
    logic [31:0] sb [$];
    logic [31:0] mon_exp;

    typedef struct {
        logic        hs;
        logic [2:0]  al;
        logic [31:0] data;
        logic [3:0]  lock;
        logic        valid;
        logic [31:0] dout;
    } vec_t;
    vec_t tv [18];

    always #5 clk = ~clk;

    dphy_hs_lane_aligner dut (
        .byte_clk_i     (clk),
        .rst_n_i        (rst_n),
        .active_lanes_i (al),
        .hs_active_i    (hs),
        .byte_data_i    (din),
        .aligned_data_o (dout),
        .aligned_valid_o(valid),
        .lane_locked_o  (locked),
        .sync_err_o     (sync_err),
        .skew_err_o     (skew_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic h, input logic [31:0] d);
        hs = h;
        din = d;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_on && valid) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got %h expected no valid word", dout);
            end else begin
                mon_exp = sb.pop_front();
                if (dout !== mon_exp) begin
                    fails++;
                    $display("FAIL sb_word: got %h expected %h", dout, mon_exp);
                end
            end
        end
    end

    // lane n byte at burst cycle c: zeros, sync at cycle 1+d, then payload seed+n+16*j
    function automatic logic [7:0] lane_val(input int n, input int c, input int d, input logic [7:0] seed);
        if (d < 0 || c < 1 + d) return 8'h00;
        if (c == 1 + d) return 8'hB8;
        return seed + 8'(n) + 8'((c - 2 - d) * 16);
    endfunction

    task automatic burst(input string nm, input logic [2:0] a, input int d0, input int d1, input int d2,
                         input int d3, input logic [7:0] seed, input int ncyc, input logic [3:0] exp_lock,
                         input int exp_sync_at, input logic exp_skew);
        int d [4];
        int ea, late, nsync, nskew, sync_at;
        logic words;
        logic [31:0] w, wexp;
        d = '{d0, d1, d2, d3};
        ea = (a == 3'd0 || a > 3'd4) ? 4 : int'(a);
        words = exp_sync_at < 0 && !exp_skew;
        late = 0;
        for (int i = 0; i < ea; i++) if (d[i] > late) late = d[i];
        nsync = 0;
        nskew = 0;
        sync_at = -1;
        al = a;
        sb_on = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            for (int n = 0; n < 4; n++) w[8*n +: 8] = lane_val(n, c, d[n], seed);
            // word j completes when the latest lane drives it; it reaches the output only
            // if HS stays up two more cycles
            if (words && c >= late + 2 && c <= ncyc - 3) begin
                wexp = '0;
                for (int n = 0; n < ea; n++) wexp[8*n +: 8] = lane_val(n, c - late + d[n], d[n], seed);
                sb.push_back(wexp);
            end
            step(1'b1, w);
            if (sync_err) begin
                nsync++;
                sync_at = c;
            end
            if (skew_err) nskew++;
        end
        chk({nm, "_lock"}, 32'(locked), 32'(exp_lock));
        step(1'b0, 32'h0);
        chk({nm, "_valid_clr"}, 32'(valid), 32'h0);
        chk({nm, "_lock_clr"}, 32'(locked), 32'h0);
        step(1'b0, 32'h0);
        chk({nm, "_drain"}, sb.size(), 0);
        chk({nm, "_sync_cnt"}, nsync, (exp_sync_at < 0) ? 0 : 1);
        if (exp_sync_at >= 0) chk({nm, "_sync_at"}, sync_at, exp_sync_at);
        chk({nm, "_skew_cnt"}, nskew, int'(exp_skew));
        sb.delete();
        sb_on = 1'b0;
    endtask

    initial begin
        // offset 0: 00,B8,11,22,.. locks when B8 sits in prev; offset 3: (00,B8,A5,5A)<<3
        tv[0]  = '{1'b0, 3'd1, 32'h00, 4'h0, 1'b0, 32'h00};
        tv[1]  = '{1'b1, 3'd1, 32'h00, 4'h0, 1'b0, 32'h00};
        tv[2]  = '{1'b1, 3'd1, 32'hB8, 4'h0, 1'b0, 32'h00};
        tv[3]  = '{1'b1, 3'd1, 32'h11, 4'h1, 1'b0, 32'h00};
        tv[4]  = '{1'b1, 3'd1, 32'h22, 4'h1, 1'b0, 32'h00};
        tv[5]  = '{1'b1, 3'd1, 32'h33, 4'h1, 1'b1, 32'h11};
        tv[6]  = '{1'b1, 3'd1, 32'h44, 4'h1, 1'b1, 32'h22};
        tv[7]  = '{1'b1, 3'd1, 32'h55, 4'h1, 1'b1, 32'h33};
        tv[8]  = '{1'b0, 3'd1, 32'h00, 4'h0, 1'b0, 32'h00};
        tv[9]  = '{1'b0, 3'd1, 32'h00, 4'h0, 1'b0, 32'h00};
        tv[10] = '{1'b1, 3'd1, 32'h00, 4'h0, 1'b0, 32'h00};
        tv[11] = '{1'b1, 3'd1, 32'hC0, 4'h0, 1'b0, 32'h00};
        tv[12] = '{1'b1, 3'd1, 32'h2D, 4'h1, 1'b0, 32'h00};
        tv[13] = '{1'b1, 3'd1, 32'hD5, 4'h1, 1'b0, 32'h00};
        tv[14] = '{1'b1, 3'd1, 32'h02, 4'h1, 1'b1, 32'hA5};
        tv[15] = '{1'b1, 3'd1, 32'h00, 4'h1, 1'b1, 32'h5A};
        tv[16] = '{1'b0, 3'd1, 32'h00, 4'h0, 1'b0, 32'h00};
        tv[17] = '{1'b0, 3'd1, 32'h00, 4'h0, 1'b0, 32'h00};

        rst_n = 1'b0;
        al = 3'd1;
        hs = 1'b0;
        din = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_data", dout, 32'h0);
        chk("rst_lock", 32'(locked), 32'h0);
        chk("rst_errs", {30'h0, sync_err, skew_err}, 32'h0);
        rst_n = 1'b1;
        step(1'b0, 32'h0);

        for (int i = 0; i < 18; i++) begin
            al = tv[i].al;
            step(tv[i].hs, tv[i].data);
            chk($sformatf("vec%0d_lock", i), 32'(locked), 32'(tv[i].lock));
            chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(tv[i].valid));
            if (tv[i].valid) chk($sformatf("vec%0d_data", i), dout, tv[i].dout);
        end

        burst("skew2", 3'd4, 0, 0, 2, 0, 8'h10, 12, 4'hF, -1, 1'b0);
        burst("timeout", 3'd2, 0, -1, 0, 0, 8'h20, 70, 4'h1, 64, 1'b0);
        burst("skew4", 3'd4, 0, 0, 0, 4, 8'h30, 12, 4'hF, -1, 1'b1);
        burst("reenter0", 3'd0, 0, 0, 0, 0, 8'h40, 10, 4'hF, -1, 1'b0);
        burst("reenter1", 3'd4, 1, 0, 3, 2, 8'h81, 14, 4'hF, -1, 1'b0);

        al = 3'd4;
        step(1'b1, 32'h00000000);
        step(1'b1, 32'hB8B8B8B8);
        step(1'b1, 32'h13121110);
        step(1'b1, 32'h23222120);
        step(1'b1, 32'h33323130);
        step(1'b1, 32'h43424140);
        chk("arst_pre_valid", 32'(valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(valid), 32'h0);
        chk("arst_lock", 32'(locked), 32'h0);
        chk("arst_data", dout, 32'h0);
        hs = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
